// File: rtl/clock_pkg.sv
// Shared constants for the divided-clock tick receiver.
//   N_CLK / CNT_W       default channel count and period counter width
//   CH_*                channel index of each divided clock
//   EXP_PERIOD_DEFAULT  expected period per channel in master_clk cycles,
//                       channel i at bits [i*CNT_W +: CNT_W]
package clock_pkg;

    localparam int unsigned N_CLK = 5;
    localparam int unsigned CNT_W = 24;

    localparam int unsigned CH_SHIP       = 0;
    localparam int unsigned CH_PROJECTILE = 1;
    localparam int unsigned CH_ALIEN      = 2;
    localparam int unsigned CH_COOLDOWN   = 3;
    localparam int unsigned CH_25MHZ      = 4;

    // Periods assume a 100 MHz master_clk.
    localparam logic [N_CLK*CNT_W-1:0] EXP_PERIOD_DEFAULT = {
        24'd4,          // CH_25MHZ
        24'd2_000_000,  // CH_COOLDOWN
        24'd1_000_000,  // CH_ALIEN
        24'd250_000,    // CH_PROJECTILE
        24'd500_000     // CH_SHIP
    };

endpackage

// File: rtl/tick_channel.sv
// One divided-clock channel of the tick receiver.
// Synchronises an asynchronous clock level, emits a one-cycle tick per qualified
// rising edge, measures the edge-to-edge period and flags dead or off-rate input.
// Ports:
//   clk_i       master clock
//   rst_i       asynchronous active-high reset
//   clk_in_i    divided clock, asynchronous level
//   clr_err_i   clears rate_err_o unless a new error arrives in the same cycle
//   tick_o      one-cycle strobe per rising edge
//   alive_o     channel has ticked since the last counter saturation
//   rate_err_o  sticky off-rate / dead-channel flag
//   period_o    last compared period in master_clk cycles
module tick_channel #(
    parameter int unsigned      CNT_W      = 24,
    parameter logic [CNT_W-1:0] EXP_PERIOD = '0,
    parameter int unsigned      TOL        = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clk_in_i,
    input  logic             clr_err_i,
    output logic             tick_o,
    output logic             alive_o,
    output logic             rate_err_o,
    output logic [CNT_W-1:0] period_o
);

    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CntMaxM1 = CntMax - CNT_W'(1);
    localparam logic [CNT_W:0]   TolW     = (CNT_W+1)'(TOL);

    logic             s1_q, s2_q, s3_q;
    logic [1:0]       prime_q, prime_d;
    logic             armed_q, armed_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             skip_q, skip_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             alive_q, alive_d;
    logic             rate_err_q, rate_err_d;

    logic             edge_det;
    logic             sat_evt;
    logic [CNT_W-1:0] measured;
    logic [CNT_W:0]   meas_ext, exp_ext, diff;
    logic             off_rate;
    logic             new_err;

    always_comb begin
        // prime_q[1] marks that s2 holds a real input sample rather than its reset
        // value, so a level already high at reset release cannot arm the channel.
        prime_d  = {prime_q[0], 1'b1};
        armed_d  = armed_q | (prime_q[1] & ~s2_q);
        edge_det = armed_q & s2_q & ~s3_q;
        tick_d   = edge_det;

        measured = (cnt_q == CntMax) ? CntMax : cnt_q + CNT_W'(1);
        // Fires once, on the edge where the counter reaches all-ones.
        sat_evt  = ~edge_det & (cnt_q == CntMaxM1);

        if (edge_det) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // One extra bit so the absolute difference cannot wrap.
        meas_ext = {1'b0, measured};
        exp_ext  = {1'b0, EXP_PERIOD};
        diff     = (meas_ext >= exp_ext) ? (meas_ext - exp_ext) : (exp_ext - meas_ext);
        off_rate = diff > TolW;

        valid_d  = valid_q;
        skip_d   = skip_q;
        period_d = period_q;
        alive_d  = alive_q;
        new_err  = 1'b0;

        if (edge_det) begin
            alive_d = 1'b1;
            skip_d  = 1'b0;
            if (!valid_q) begin
                valid_d = 1'b1;
            end else if (!skip_q) begin
                period_d = measured;
                new_err  = off_rate;
            end
        end else if (sat_evt) begin
            alive_d = 1'b0;
            if (valid_q) begin
                new_err = 1'b1;
                // The interval spanning the dead period is meaningless.
                skip_d  = 1'b1;
            end
        end

        if (new_err) begin
            rate_err_d = 1'b1;
        end else if (clr_err_i) begin
            rate_err_d = 1'b0;
        end else begin
            rate_err_d = rate_err_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            prime_q    <= '0;
            armed_q    <= 1'b0;
            tick_q     <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            skip_q     <= 1'b0;
            period_q   <= '0;
            alive_q    <= 1'b0;
            rate_err_q <= 1'b0;
        end else begin
            s1_q       <= clk_in_i;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            prime_q    <= prime_d;
            armed_q    <= armed_d;
            tick_q     <= tick_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            skip_q     <= skip_d;
            period_q   <= period_d;
            alive_q    <= alive_d;
            rate_err_q <= rate_err_d;
        end
    end

    assign tick_o     = tick_q;
    assign alive_o    = alive_q;
    assign rate_err_o = rate_err_q;
    assign period_o   = period_q;

endmodule

// File: rtl/clock_tick_receiver.sv
// Receiving end of the divided-clock outputs. Each divided clock becomes a
// one-cycle tick in the master_clk domain, with period measurement and health flags.
// Ports:
//   master_clk       sole clock
//   RESET_debounced  asynchronous active-high reset
//   clk_in           divided clocks, asynchronous levels
//   clr_err          pulse clearing all rate_err bits
//   sel              channel select for period readback
//   tick             one-cycle strobe per channel rising edge
//   alive            channel has ticked since its last counter saturation
//   rate_err         sticky off-rate flags
//   period_out       last valid period of channel sel (one-cycle latency, 0 if sel out of range)
module clock_tick_receiver #(
    parameter int unsigned              N_CLK      = clock_pkg::N_CLK,
    parameter int unsigned              CNT_W      = clock_pkg::CNT_W,
    parameter logic [N_CLK*CNT_W-1:0]   EXP_PERIOD = clock_pkg::EXP_PERIOD_DEFAULT,
    parameter int unsigned              TOL        = 2,
    localparam int unsigned             SEL_W      = (N_CLK > 1) ? $clog2(N_CLK) : 1
) (
    input  logic             master_clk,
    input  logic             RESET_debounced,
    input  logic [N_CLK-1:0] clk_in,
    input  logic             clr_err,
    input  logic [SEL_W-1:0] sel,
    output logic [N_CLK-1:0] tick,
    output logic [N_CLK-1:0] alive,
    output logic [N_CLK-1:0] rate_err,
    output logic [CNT_W-1:0] period_out
);

    logic [CNT_W-1:0] period_reg [N_CLK];
    logic [CNT_W-1:0] period_out_d;

    for (genvar i = 0; i < N_CLK; i++) begin : g_ch
        tick_channel #(
            .CNT_W      (CNT_W),
            .EXP_PERIOD (EXP_PERIOD[i*CNT_W +: CNT_W]),
            .TOL        (TOL)
        ) u_ch (
            .clk_i      (master_clk),
            .rst_i      (RESET_debounced),
            .clk_in_i   (clk_in[i]),
            .clr_err_i  (clr_err),
            .tick_o     (tick[i]),
            .alive_o    (alive[i]),
            .rate_err_o (rate_err[i]),
            .period_o   (period_reg[i])
        );
    end

    always_comb begin
        period_out_d = '0;
        if (32'(sel) < N_CLK) begin
            period_out_d = period_reg[sel];
        end
    end

    always_ff @(posedge master_clk or posedge RESET_debounced) begin
        if (RESET_debounced) begin
            period_out <= '0;
        end else begin
            period_out <= period_out_d;
        end
    end

endmodule

// File: tb/tb_clock_tick_receiver.sv
module tb_clock_tick_receiver;

    logic       master_clk = 1'b0;
    logic       rst        = 1'b1;
    logic [1:0] clk_in     = 2'b00;
    logic       clr_err    = 1'b0;
    logic [0:0] sel        = 1'b0;
    logic [1:0] tick, alive, rate_err;
    logic [7:0] period_out;

    int errors = 0;
    int checks = 0;

    clock_tick_receiver #(
        .N_CLK      (2),
        .CNT_W      (8),
        .EXP_PERIOD ({8'd20, 8'd8}),
        .TOL        (1)
    ) dut (
        .master_clk      (master_clk),
        .RESET_debounced (rst),
        .clk_in          (clk_in),
        .clr_err         (clr_err),
        .sel             (sel),
        .tick            (tick),
        .alive           (alive),
        .rate_err        (rate_err),
        .period_out      (period_out)
    );

    always #5 master_clk = ~master_clk;

    // Square-wave generators: per_cfg==0 holds lvl_cfg, otherwise high for per/2 cycles.
    int per_cfg [2] = '{0, 0};
    bit lvl_cfg [2] = '{0, 0};
    int ph      [2] = '{0, 0};

    always @(posedge master_clk) begin
        #1;
        for (int c = 0; c < 2; c++) begin
            if (per_cfg[c] == 0) begin
                clk_in[c] = lvl_cfg[c];
            end else begin
                clk_in[c] = (ph[c] < per_cfg[c] / 2);
                ph[c] = (ph[c] + 1) % per_cfg[c];
            end
        end
    end

    // Reference model: edges counted from reset release; input samples kept as history.
    int         n;
    bit         hist1 [2], hist2 [2], hist3 [2];
    int         ref_edge [2];
    bit         m_valid [2], m_skip [2];
    int         m_prd [2];
    int         exp_p [2] = '{8, 20};
    logic [1:0] e_tick, e_alive, e_err;
    logic [7:0] e_pout;
    int         m_age, m_meas, m_diff;
    bit         m_tk, m_new;

    always @(posedge master_clk or posedge rst) begin
        if (rst) begin
            n = 0;
            for (int c = 0; c < 2; c++) begin
                hist1[c] = 0; hist2[c] = 0; hist3[c] = 0;
                ref_edge[c] = 0; m_valid[c] = 0; m_skip[c] = 0; m_prd[c] = 0;
            end
            e_tick = '0; e_alive = '0; e_err = '0; e_pout = '0;
        end else begin
            n++;
            e_pout = 8'(m_prd[sel]);
            for (int c = 0; c < 2; c++) begin
                // Rising edge sampled at edge n-2 after a low sample at n-3.
                m_tk  = (n >= 4) && hist2[c] && !hist3[c];
                m_age = n - ref_edge[c];
                m_new = 0;
                if (m_tk) begin
                    m_meas = (m_age > 255) ? 255 : m_age;
                    e_alive[c] = 1'b1;
                    if (!m_valid[c]) begin
                        m_valid[c] = 1;
                    end else if (m_skip[c]) begin
                        m_skip[c] = 0;
                    end else begin
                        m_prd[c] = m_meas;
                        m_diff = (m_meas > exp_p[c]) ? m_meas - exp_p[c] : exp_p[c] - m_meas;
                        if (m_diff > 1) m_new = 1;
                    end
                    ref_edge[c] = n;
                end else if (m_age == 255) begin
                    e_alive[c] = 1'b0;
                    if (m_valid[c]) begin
                        m_new = 1;
                        m_skip[c] = 1;
                    end
                end
                if (m_new) e_err[c] = 1'b1;
                else if (clr_err) e_err[c] = 1'b0;
                e_tick[c] = m_tk;
                hist3[c] = hist2[c];
                hist2[c] = hist1[c];
                hist1[c] = clk_in[c];
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        per_cfg[0] = 0; per_cfg[1] = 0; lvl_cfg[0] = 0; lvl_cfg[1] = 0;
        repeat (5) begin
            @(negedge master_clk);
            checks++;
            if ({tick, alive, rate_err, period_out} !== 14'h0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0", {tick, alive, rate_err, period_out});
            end
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge master_clk);
            checks++;
            if (tick !== 2'b00) begin
                errors++;
                $display("FAIL idle_no_tick: got %b expected 00", tick);
            end
        end
    endtask

    task automatic test_period_match();
        sel = 1'b0;
        ph[0] = 0; per_cfg[0] = 8;
        repeat (60) begin
            @(negedge master_clk);
            checks++;
            if ({tick, alive, rate_err, period_out} !== {e_tick, e_alive, e_err, e_pout}) begin
                errors++;
                $display("FAIL model_period8 @%0t: got %h expected %h", $time,
                         {tick, alive, rate_err, period_out}, {e_tick, e_alive, e_err, e_pout});
            end
        end
        checks++;
        if ({period_out, alive[0], rate_err[0]} !== {8'd8, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL period8_status: got period=%0d alive=%b err=%b expected 8 1 0",
                     period_out, alive[0], rate_err[0]);
        end
    endtask

    task automatic test_off_rate_clr();
        int seen = 0;
        sel = 1'b1;
        ph[1] = 0; per_cfg[1] = 23;
        for (int i = 0; i < 120 && seen < 2; i++) begin
            @(negedge master_clk);
            checks++;
            if ({tick, alive, rate_err, period_out} !== {e_tick, e_alive, e_err, e_pout}) begin
                errors++;
                $display("FAIL model_off_rate @%0t: got %h expected %h", $time,
                         {tick, alive, rate_err, period_out}, {e_tick, e_alive, e_err, e_pout});
            end
            if (tick[1]) seen++;
        end
        checks++;
        if (rate_err[1] !== 1'b1 || seen != 2) begin
            errors++;
            $display("FAIL off_rate_flag: got err=%b ticks=%0d expected 1 2", rate_err[1], seen);
        end
        clr_err = 1'b1;
        @(negedge master_clk);
        clr_err = 1'b0;
        checks++;
        if (rate_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_new_err: got %b expected 0", rate_err[1]);
        end
        checks++;
        if (period_out !== 8'd23) begin
            errors++;
            $display("FAIL period_out_ch1: got %0d expected 23", period_out);
        end
        repeat (21) begin
            @(negedge master_clk);
            checks++;
            if ({tick, alive, rate_err, period_out} !== {e_tick, e_alive, e_err, e_pout}) begin
                errors++;
                $display("FAIL model_clr_wait @%0t: got %h expected %h", $time,
                         {tick, alive, rate_err, period_out}, {e_tick, e_alive, e_err, e_pout});
            end
        end
        clr_err = 1'b1;
        @(negedge master_clk);
        clr_err = 1'b0;
        checks++;
        if ({tick[1], rate_err[1]} !== 2'b11) begin
            errors++;
            $display("FAIL clr_vs_err: got tick=%b err=%b expected 1 1", tick[1], rate_err[1]);
        end
    endtask

    task automatic test_high_at_reset();
        int seen = 0;
        rst = 1'b1;
        per_cfg[0] = 0; lvl_cfg[0] = 1;
        per_cfg[1] = 0; lvl_cfg[1] = 0;
        sel = 1'b0;
        repeat (3) @(negedge master_clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge master_clk);
            checks++;
            if (tick[0] !== 1'b0) begin
                errors++;
                $display("FAIL high_at_release: got tick=%b expected 0", tick[0]);
            end
        end
        lvl_cfg[0] = 0;
        repeat (6) @(negedge master_clk);
        ph[0] = 0; per_cfg[0] = 8;
        repeat (50) begin
            @(negedge master_clk);
            checks++;
            if ({tick, alive, rate_err, period_out} !== {e_tick, e_alive, e_err, e_pout}) begin
                errors++;
                $display("FAIL model_high_reset @%0t: got %h expected %h", $time,
                         {tick, alive, rate_err, period_out}, {e_tick, e_alive, e_err, e_pout});
            end
            if (tick[0]) seen++;
        end
        checks++;
        if (rate_err[0] !== 1'b0 || seen < 2 || period_out !== 8'd8) begin
            errors++;
            $display("FAIL first_period_skip: got err=%b ticks=%0d period=%0d expected 0 >=2 8",
                     rate_err[0], seen, period_out);
        end
    endtask

    task automatic test_stall_restart();
        bit found = 0;
        per_cfg[0] = 0; lvl_cfg[0] = 0;
        repeat (270) begin
            @(negedge master_clk);
            checks++;
            if ({tick, alive, rate_err, period_out} !== {e_tick, e_alive, e_err, e_pout}) begin
                errors++;
                $display("FAIL model_stall @%0t: got %h expected %h", $time,
                         {tick, alive, rate_err, period_out}, {e_tick, e_alive, e_err, e_pout});
            end
        end
        checks++;
        if ({alive[0], rate_err[0]} !== 2'b01) begin
            errors++;
            $display("FAIL stall_flags: got alive=%b err=%b expected 0 1", alive[0], rate_err[0]);
        end
        clr_err = 1'b1;
        @(negedge master_clk);
        clr_err = 1'b0;
        ph[0] = 0; per_cfg[0] = 8;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge master_clk);
            if (tick[0]) begin
                found = 1;
                checks++;
                if (alive[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_alive: got %b expected 1", alive[0]);
                end
            end
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL restart_tick: got none expected a tick within 20 cycles");
        end
        repeat (30) begin
            @(negedge master_clk);
            checks++;
            if ({tick, alive, rate_err, period_out} !== {e_tick, e_alive, e_err, e_pout}) begin
                errors++;
                $display("FAIL model_restart @%0t: got %h expected %h", $time,
                         {tick, alive, rate_err, period_out}, {e_tick, e_alive, e_err, e_pout});
            end
        end
        checks++;
        if (rate_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL restart_no_err: got %b expected 0", rate_err[0]);
        end
    endtask

    task automatic test_reset_mid();
        ph[0] = 0; per_cfg[0] = 8;
        ph[1] = 0; per_cfg[1] = 23;
        repeat (40 + $urandom_range(0, 20)) @(negedge master_clk);
        @(posedge master_clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tick, alive, rate_err, period_out} !== 14'h0) begin
            errors++;
            $display("FAIL mid_reset_now: got %h expected 0", {tick, alive, rate_err, period_out});
        end
        @(negedge master_clk);
        @(negedge master_clk);
        checks++;
        if ({tick, alive, rate_err, period_out} !== 14'h0) begin
            errors++;
            $display("FAIL mid_reset_hold: got %h expected 0", {tick, alive, rate_err, period_out});
        end
        rst = 1'b0;
        repeat (80) begin
            @(negedge master_clk);
            checks++;
            if ({tick, alive, rate_err, period_out} !== {e_tick, e_alive, e_err, e_pout}) begin
                errors++;
                $display("FAIL model_after_reset @%0t: got %h expected %h", $time,
                         {tick, alive, rate_err, period_out}, {e_tick, e_alive, e_err, e_pout});
            end
        end
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 6; blk++) begin
            for (int c = 0; c < 2; c++) begin
                ph[c] = 0;
                per_cfg[c] = int'($urandom_range(4, 30));
            end
            repeat (100) begin
                @(negedge master_clk);
                checks++;
                if ({tick, alive, rate_err, period_out} !== {e_tick, e_alive, e_err, e_pout}) begin
                    errors++;
                    $display("FAIL model_random @%0t: got %h expected %h", $time,
                             {tick, alive, rate_err, period_out}, {e_tick, e_alive, e_err, e_pout});
                end
                sel     = 1'($urandom_range(0, 1));
                clr_err = ($urandom_range(0, 15) == 0);
            end
        end
        clr_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_period_match();
        test_off_rate_clr();
        test_high_at_reset();
        test_stall_restart();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
